wts_sram_arbiter: RTL and testbench

- Owns the single access path to the wave-table SRAM banks (bank 0 = A0..E0, bank 1 = A1..E1).
- Shares that path between two requesters:
  - the channel mixer's sample-fetch slots, which have absolute priority and fixed latency;
  - the CPU register port (wave-table read/write), which is buffered one-deep and served in free slots.
- Drives the SRAM command pins, steers returned read data to the correct requester, and flags CPU starvation and overrun.

---
 rtl/wts_sram_arbiter.sv | 179 +++++++++++++++++
 tb/tb_wts_sram_arbiter.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wts_sram_arbiter.sv
// Wave-table SRAM arbiter: sound fetches take every slot they ask for; a one-deep
// buffered CPU request is served in free slots, with starvation and overrun flags.
module wts_sram_arbiter #(
    parameter int unsigned STARVE_LIMIT = 15
) (
    input  logic       clk,
    input  logic       nreset,
    input  logic       snd_req,
    input  logic       snd_bank,
    input  logic [2:0] snd_id,
    input  logic [6:0] snd_a,
    output logic [7:0] snd_q,
    output logic       snd_q_valid,
    input  logic       cpu_req,
    input  logic       cpu_we,
    input  logic       cpu_bank,
    input  logic [2:0] cpu_id,
    input  logic [6:0] cpu_a,
    input  logic [7:0] cpu_d,
    output logic [7:0] cpu_q,
    output logic       cpu_ack,
    output logic       cpu_busy,
    output logic       cpu_starve,
    output logic       cpu_overrun,
    output logic       sram_ce0,
    output logic       sram_ce1,
    output logic [2:0] sram_id,
    output logic [6:0] sram_a,
    output logic [7:0] sram_d,
    output logic       sram_oe,
    output logic       sram_we,
    input  logic [7:0] sram_q,
    input  logic       sram_q_en
);

    localparam int unsigned ID_W  = 3;
    localparam int unsigned A_W   = 7;
    localparam int unsigned D_W   = 8;
    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PEND   = 2'd1,
        RDWAIT = 2'd2
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   wait_cnt;
    logic [CNT_W-1:0]   wait_cnt_inc;

    logic               buf_we;
    logic               buf_bank;
    logic [ID_W-1:0]    buf_id;
    logic [A_W-1:0]     buf_a;
    logic [D_W-1:0]     buf_d;

    // tag1 is aligned with the command on the pins, tag2 with the returning data
    logic               tag1_vld;
    logic               tag1_cpu;
    logic               tag2_vld;
    logic               tag2_cpu;

    assign wait_cnt_inc = (wait_cnt == CNT_MAX) ? CNT_MAX : wait_cnt + CNT_W'(1);

    // Sound data is a passthrough qualified by the return tag
    always_comb begin
        snd_q_valid = sram_q_en & tag2_vld & ~tag2_cpu;
        snd_q       = snd_q_valid ? sram_q : '0;
    end

    always_ff @(posedge clk) begin
        if (!nreset) begin
            state       <= IDLE;
            wait_cnt    <= '0;
            buf_we      <= 1'b0;
            buf_bank    <= 1'b0;
            buf_id      <= '0;
            buf_a       <= '0;
            buf_d       <= '0;
            tag1_vld    <= 1'b0;
            tag1_cpu    <= 1'b0;
            tag2_vld    <= 1'b0;
            tag2_cpu    <= 1'b0;
            cpu_q       <= '0;
            cpu_ack     <= 1'b0;
            cpu_busy    <= 1'b0;
            cpu_starve  <= 1'b0;
            cpu_overrun <= 1'b0;
            sram_ce0    <= 1'b0;
            sram_ce1    <= 1'b0;
            sram_id     <= '0;
            sram_a      <= '0;
            sram_d      <= '0;
            sram_oe     <= 1'b0;
            sram_we     <= 1'b0;
        end else begin
            sram_ce0 <= 1'b0;
            sram_ce1 <= 1'b0;
            sram_id  <= '0;
            sram_a   <= '0;
            sram_d   <= '0;
            sram_oe  <= 1'b0;
            sram_we  <= 1'b0;
            cpu_ack  <= 1'b0;
            tag1_vld <= 1'b0;
            tag1_cpu <= 1'b0;
            tag2_vld <= tag1_vld;
            tag2_cpu <= tag1_cpu;

            // Sound fetch owns the slot whenever it asks
            if (snd_req) begin
                sram_ce0 <= ~snd_bank;
                sram_ce1 <= snd_bank;
                sram_oe  <= 1'b1;
                sram_id  <= snd_id;
                sram_a   <= snd_a;
                tag1_vld <= 1'b1;
            end

            // A request arriving while the buffer is in use, or on the ack cycle, is lost
            if (cpu_req && (state != IDLE || cpu_ack)) begin
                cpu_overrun <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (cpu_req && !cpu_ack) begin
                        buf_we   <= cpu_we;
                        buf_bank <= cpu_bank;
                        buf_id   <= cpu_id;
                        buf_a    <= cpu_a;
                        buf_d    <= cpu_d;
                        cpu_busy <= 1'b1;
                        state    <= PEND;
                    end
                end
                PEND: begin
                    if (snd_req) begin
                        wait_cnt <= wait_cnt_inc;
                        if (32'(wait_cnt_inc) >= STARVE_LIMIT) begin
                            cpu_starve <= 1'b1;
                        end
                    end else begin
                        wait_cnt <= '0;
                        sram_ce0 <= ~buf_bank;
                        sram_ce1 <= buf_bank;
                        sram_id  <= buf_id;
                        sram_a   <= buf_a;
                        if (buf_we) begin
                            sram_we  <= 1'b1;
                            sram_d   <= buf_d;
                            cpu_ack  <= 1'b1;
                            cpu_busy <= 1'b0;
                            state    <= IDLE;
                        end else begin
                            sram_oe  <= 1'b1;
                            tag1_vld <= 1'b1;
                            tag1_cpu <= 1'b1;
                            state    <= RDWAIT;
                        end
                    end
                end
                RDWAIT: begin
                    if (sram_q_en && tag2_vld && tag2_cpu) begin
                        cpu_q    <= sram_q;
                        cpu_ack  <= 1'b1;
                        cpu_busy <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wts_sram_arbiter.sv
// Directed bench for wts_sram_arbiter; each task drives one scenario and checks
// hand-computed cycle-exact responses.
module tb_wts_sram_arbiter;

    logic       clk = 1'b0;
    logic       nreset;
    logic       snd_req;
    logic       snd_bank;
    logic [2:0] snd_id;
    logic [6:0] snd_a;
    logic [7:0] snd_q;
    logic       snd_q_valid;
    logic       cpu_req;
    logic       cpu_we;
    logic       cpu_bank;
    logic [2:0] cpu_id;
    logic [6:0] cpu_a;
    logic [7:0] cpu_d;
    logic [7:0] cpu_q;
    logic       cpu_ack;
    logic       cpu_busy;
    logic       cpu_starve;
    logic       cpu_overrun;
    logic       sram_ce0;
    logic       sram_ce1;
    logic [2:0] sram_id;
    logic [6:0] sram_a;
    logic [7:0] sram_d;
    logic       sram_oe;
    logic       sram_we;
    logic [7:0] sram_q;
    logic       sram_q_en;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    wts_sram_arbiter #(.STARVE_LIMIT(15)) dut (
        .clk(clk), .nreset(nreset),
        .snd_req(snd_req), .snd_bank(snd_bank), .snd_id(snd_id), .snd_a(snd_a),
        .snd_q(snd_q), .snd_q_valid(snd_q_valid),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_bank(cpu_bank), .cpu_id(cpu_id),
        .cpu_a(cpu_a), .cpu_d(cpu_d), .cpu_q(cpu_q), .cpu_ack(cpu_ack),
        .cpu_busy(cpu_busy), .cpu_starve(cpu_starve), .cpu_overrun(cpu_overrun),
        .sram_ce0(sram_ce0), .sram_ce1(sram_ce1), .sram_id(sram_id), .sram_a(sram_a),
        .sram_d(sram_d), .sram_oe(sram_oe), .sram_we(sram_we),
        .sram_q(sram_q), .sram_q_en(sram_q_en)
    );

    // Advance one cycle; inputs set after this apply to the new cycle
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        snd_req = 0; snd_bank = 0; snd_id = 0; snd_a = 0;
        cpu_req = 0; cpu_we = 0; cpu_bank = 0; cpu_id = 0; cpu_a = 0; cpu_d = 0;
        sram_q = 0; sram_q_en = 0;
    endtask

    task automatic test_reset();
        logic [26:0] got;
        idle_inputs();
        nreset = 0;
        tick(); tick();
        nreset = 1;
        got = {sram_ce0, sram_ce1, sram_id, sram_a, sram_d, sram_oe, sram_we, cpu_ack, cpu_busy, cpu_starve, cpu_overrun};
        total++;
        if (got !== 27'd0) begin
            bad++; $display("FAIL reset_outputs got=%h want=0", got);
        end
        total++;
        if (cpu_q !== 8'h00 || snd_q_valid !== 1'b0) begin
            bad++; $display("FAIL reset_data cpu_q=%h snd_q_valid=%b want 00/0", cpu_q, snd_q_valid);
        end
        tick();
    endtask

    task automatic test_snd_fetch();
        snd_req = 1; snd_bank = 1; snd_id = 3'd2; snd_a = 7'h15;
        tick();
        snd_req = 0; snd_bank = 0; snd_id = 0; snd_a = 0;
        total++;
        if ({sram_ce0, sram_ce1, sram_oe, sram_we, sram_id, sram_a} !== {1'b0, 1'b1, 1'b1, 1'b0, 3'd2, 7'h15}) begin
            bad++; $display("FAIL snd_cmd ce0=%b ce1=%b oe=%b we=%b id=%0d a=%h want 0 1 1 0 2 15",
                            sram_ce0, sram_ce1, sram_oe, sram_we, sram_id, sram_a);
        end
        tick();
        sram_q_en = 1; sram_q = 8'hA5;
        #1;
        total++;
        if (snd_q_valid !== 1'b1 || snd_q !== 8'hA5) begin
            bad++; $display("FAIL snd_data valid=%b q=%h want 1 a5", snd_q_valid, snd_q);
        end
        total++;
        if (sram_oe !== 1'b0 || sram_ce1 !== 1'b0) begin
            bad++; $display("FAIL snd_idle_slot oe=%b ce1=%b want 0 0", sram_oe, sram_ce1);
        end
        tick();
        sram_q_en = 0; sram_q = 0;
        tick();
    endtask

    task automatic test_cpu_write();
        cpu_req = 1; cpu_we = 1; cpu_bank = 0; cpu_id = 3'd1; cpu_a = 7'h7F; cpu_d = 8'h3C;
        tick();
        cpu_req = 0;
        total++;
        if (cpu_busy !== 1'b1 || sram_ce0 !== 1'b0 || cpu_ack !== 1'b0) begin
            bad++; $display("FAIL wr_pend busy=%b ce0=%b ack=%b want 1 0 0", cpu_busy, sram_ce0, cpu_ack);
        end
        tick();
        total++;
        if ({sram_ce0, sram_ce1, sram_we, sram_oe, sram_a, sram_d, sram_id} !== {1'b1, 1'b0, 1'b1, 1'b0, 7'h7F, 8'h3C, 3'd1}) begin
            bad++; $display("FAIL wr_cmd ce0=%b ce1=%b we=%b oe=%b a=%h d=%h id=%0d want 1 0 1 0 7f 3c 1",
                            sram_ce0, sram_ce1, sram_we, sram_oe, sram_a, sram_d, sram_id);
        end
        total++;
        if (cpu_ack !== 1'b1 || cpu_busy !== 1'b0) begin
            bad++; $display("FAIL wr_ack ack=%b busy=%b want 1 0", cpu_ack, cpu_busy);
        end
        tick();
        total++;
        if (cpu_ack !== 1'b0 || sram_we !== 1'b0 || sram_d !== 8'h00) begin
            bad++; $display("FAIL wr_after ack=%b we=%b d=%h want 0 0 00", cpu_ack, sram_we, sram_d);
        end
    endtask

    task automatic test_cpu_read_blocked();
        int errs;
        cpu_req = 1; cpu_we = 0; cpu_bank = 1; cpu_id = 3'd4; cpu_a = 7'h22; cpu_d = 8'hFF;
        snd_req = 1; snd_bank = 0; snd_id = 3'd1; snd_a = 7'h10;
        tick();
        cpu_req = 0;
        errs = 0;
        for (int i = 0; i < 3; i++) begin
            if (!(sram_ce0 === 1'b1 && sram_oe === 1'b1 && sram_a === 7'h10 && sram_ce1 === 1'b0)) errs++;
            tick();
        end
        snd_req = 0;
        if (!(sram_ce0 === 1'b1 && sram_a === 7'h10)) errs++;
        total++;
        if (errs !== 0) begin
            bad++; $display("FAIL rd_snd_slots bad_cycles=%0d want 0", errs);
        end
        tick();
        total++;
        if ({sram_ce0, sram_ce1, sram_oe, sram_we, sram_id, sram_a} !== {1'b0, 1'b1, 1'b1, 1'b0, 3'd4, 7'h22}) begin
            bad++; $display("FAIL rd_cmd ce0=%b ce1=%b oe=%b we=%b id=%0d a=%h want 0 1 1 0 4 22",
                            sram_ce0, sram_ce1, sram_oe, sram_we, sram_id, sram_a);
        end
        tick();
        sram_q_en = 1; sram_q = 8'h5A;
        #1;
        total++;
        if (snd_q_valid !== 1'b0 || cpu_ack !== 1'b0) begin
            bad++; $display("FAIL rd_return snd_q_valid=%b ack=%b want 0 0", snd_q_valid, cpu_ack);
        end
        tick();
        sram_q_en = 0; sram_q = 0;
        total++;
        if (cpu_ack !== 1'b1 || cpu_q !== 8'h5A || cpu_busy !== 1'b0 || cpu_starve !== 1'b0) begin
            bad++; $display("FAIL rd_ack ack=%b q=%h busy=%b starve=%b want 1 5a 0 0", cpu_ack, cpu_q, cpu_busy, cpu_starve);
        end
        tick();
        total++;
        if (cpu_ack !== 1'b0 || cpu_q !== 8'h5A) begin
            bad++; $display("FAIL rd_hold ack=%b q=%h want 0 5a", cpu_ack, cpu_q);
        end
    endtask

    task automatic test_starve();
        cpu_req = 1; cpu_we = 1; cpu_bank = 1; cpu_id = 3'd3; cpu_a = 7'h40; cpu_d = 8'h99;
        snd_req = 1; snd_bank = 0; snd_id = 0; snd_a = 7'h01;
        tick();
        cpu_req = 0;
        for (int i = 0; i < 14; i++) tick();
        total++;
        if (cpu_starve !== 1'b0) begin
            bad++; $display("FAIL starve_early starve=%b want 0", cpu_starve);
        end
        tick();
        snd_req = 0;
        total++;
        if (cpu_starve !== 1'b1 || cpu_busy !== 1'b1) begin
            bad++; $display("FAIL starve_set starve=%b busy=%b want 1 1", cpu_starve, cpu_busy);
        end
        tick();
        total++;
        if (cpu_ack !== 1'b1 || sram_we !== 1'b1 || sram_ce1 !== 1'b1 || sram_a !== 7'h40 || sram_d !== 8'h99) begin
            bad++; $display("FAIL starve_done ack=%b we=%b ce1=%b a=%h d=%h want 1 1 1 40 99",
                            cpu_ack, sram_we, sram_ce1, sram_a, sram_d);
        end
        tick(); tick();
        total++;
        if (cpu_starve !== 1'b1) begin
            bad++; $display("FAIL starve_sticky starve=%b want 1", cpu_starve);
        end
    endtask

    task automatic test_overrun();
        int acks;
        cpu_req = 1; cpu_we = 1; cpu_bank = 0; cpu_id = 0; cpu_a = 7'h01; cpu_d = 8'h11;
        snd_req = 1; snd_a = 7'h05;
        tick();
        cpu_a = 7'h02; cpu_d = 8'h22;
        total++;
        if (cpu_overrun !== 1'b0 || cpu_busy !== 1'b1) begin
            bad++; $display("FAIL ovr_before overrun=%b busy=%b want 0 1", cpu_overrun, cpu_busy);
        end
        tick();
        cpu_req = 0; snd_req = 0;
        total++;
        if (cpu_overrun !== 1'b1) begin
            bad++; $display("FAIL ovr_flag overrun=%b want 1", cpu_overrun);
        end
        tick();
        total++;
        if (cpu_ack !== 1'b1 || sram_a !== 7'h01 || sram_d !== 8'h11 || sram_we !== 1'b1) begin
            bad++; $display("FAIL ovr_first ack=%b a=%h d=%h we=%b want 1 01 11 1", cpu_ack, sram_a, sram_d, sram_we);
        end
        acks = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (cpu_ack === 1'b1 || sram_we === 1'b1) acks++;
        end
        total++;
        if (acks !== 0 || cpu_overrun !== 1'b1 || cpu_busy !== 1'b0) begin
            bad++; $display("FAIL ovr_single extra=%0d overrun=%b busy=%b want 0 1 0", acks, cpu_overrun, cpu_busy);
        end
    endtask

    task automatic test_reset_rdwait();
        logic [21:0] pins;
        int acks;
        cpu_req = 1; cpu_we = 0; cpu_bank = 0; cpu_id = 3'd5; cpu_a = 7'h33;
        tick();
        cpu_req = 0;
        tick();
        total++;
        if (sram_oe !== 1'b1 || sram_a !== 7'h33) begin
            bad++; $display("FAIL rst_rd_cmd oe=%b a=%h want 1 33", sram_oe, sram_a);
        end
        nreset = 0;
        tick();
        nreset = 1;
        sram_q_en = 1; sram_q = 8'hEE;
        #1;
        pins = {sram_ce0, sram_ce1, sram_id, sram_a, sram_d, sram_oe, sram_we};
        total++;
        if (pins !== 22'd0 || snd_q_valid !== 1'b0 || cpu_busy !== 1'b0) begin
            bad++; $display("FAIL rst_pins pins=%h snd_q_valid=%b busy=%b want 0 0 0", pins, snd_q_valid, cpu_busy);
        end
        total++;
        if (cpu_starve !== 1'b0 || cpu_overrun !== 1'b0) begin
            bad++; $display("FAIL rst_sticky starve=%b overrun=%b want 0 0", cpu_starve, cpu_overrun);
        end
        acks = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            sram_q_en = 0; sram_q = 0;
            if (cpu_ack === 1'b1) acks++;
        end
        total++;
        if (acks !== 0 || cpu_q !== 8'h00) begin
            bad++; $display("FAIL rst_no_ack acks=%0d cpu_q=%h want 0 00", acks, cpu_q);
        end
        cpu_req = 1; cpu_we = 1; cpu_bank = 1; cpu_id = 3'd2; cpu_a = 7'h0A; cpu_d = 8'h77;
        tick();
        cpu_req = 0;
        tick();
        total++;
        if (cpu_ack !== 1'b1 || sram_ce1 !== 1'b1 || sram_d !== 8'h77) begin
            bad++; $display("FAIL rst_idle_after ack=%b ce1=%b d=%h want 1 1 77", cpu_ack, sram_ce1, sram_d);
        end
    endtask

    initial begin
        idle_inputs();
        nreset = 0;
        test_reset();
        test_snd_fetch();
        test_cpu_write();
        test_cpu_read_blocked();
        test_starve();
        test_overrun();
        test_reset_rdwait();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
